uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 868, SHALL set clock cycles per bit period (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set byte-buffer depth; power of two, 2..256.
REQ-003 Parameter PARITY_EN, default 0, SHALL insert an even-parity bit after data bit 7 when 1.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop-bit count; legal values 1 or 2.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tx_data  input  8  byte to send, LSB transmitted first.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 tx_ready  output  1  block accepts a byte this cycle.
REQ-010 uart_tx  output  1  serial line, idle high, registered.
REQ-011 tx_busy  output  1  high while a frame is on the line.
REQ-012 tx_done  output  1  one-cycle strobe at the end of each frame's last stop bit.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO, excluding the frame in flight.

Function
REQ-014 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both high, and SHALL be written to the FIFO tail.
REQ-015 tx_ready SHALL equal (fifo_count != FIFO_DEPTH) combinationally; a pop in the same cycle SHALL NOT raise it.
REQ-016 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve byte order.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: uart_tx=1; when fifo_count>0, the FSM SHALL pop the head byte and enter START, driving uart_tx=0 on that same edge.
REQ-019 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce the uart_tx falling edge at edge N+1.
REQ-020 Each START, DATA-bit, PARITY and STOP bit SHALL hold uart_tx stable for exactly BAUD_DIV cycles, timed by a down-counter reloaded to BAUD_DIV-1.
REQ-021 DATA SHALL shift out bits 0..7 in order, then enter PARITY if PARITY_EN=1, otherwise STOP.
REQ-022 PARITY SHALL drive the XOR of the 8 data bits.
REQ-023 STOP SHALL drive 1 for STOP_BITS*BAUD_DIV cycles and assert tx_done on its final cycle.
REQ-024 On leaving STOP with fifo_count>0, the next START SHALL begin on the following edge, with no idle gap; otherwise the FSM SHALL enter IDLE.
REQ-025 tx_busy SHALL be high in every state except IDLE.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 The bit counter and baud counter SHALL be sized for the parameter maximums, with no overflow at BAUD_DIV=65535.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: FSM=IDLE, uart_tx=1, tx_busy=0, tx_done=0, fifo_count=0, pointers=0, counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents; the line SHALL return high within the assertion.
REQ-030 Deassertion SHALL be synchronised to clk by a 2-FF reset synchroniser inside the block; tx_ready SHALL be low while reset is asserted.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state enum (tx_state_t), the default BAUD_DIV constant, and a parity helper function.
REQ-032 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width and depth, with push/pop/count ports, reusable by a future buffered receiver.

Verification (simulate with BAUD_DIV=4 unless stated)
REQ-033 Push 0x55 into an idle block at edge N -> uart_tx low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; tx_done pulses once.
REQ-034 Push 0x41, 0x42, 0x43 on consecutive cycles -> three frames back-to-back with no idle gap; fifo_count peaks at 2; decoded bytes arrive in order.
REQ-035 Hold tx_valid high with FIFO_DEPTH=4 -> 4 bytes buffered plus 1 in flight; tx_ready drops at count 4 and re-rises one cycle after the next pop; no byte is lost or duplicated.
REQ-036 PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit 1 follows bit 7; the line stays high 8 cycles before tx_done.
REQ-037 Assert rst_n low during data bit 3 with 2 bytes queued -> uart_tx=1 and fifo_count=0 asynchronously; after release, no residual frame is sent.
REQ-038 Loopback into the existing receiver at BAUD_DIV=868 with all 256 byte values -> every byte is received exactly once, in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divisor
// and the parity helper used by transmit (and later receive) paths.
package uart_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. The popped word appears on pop_data
// in the cycle after the pop and holds until the next pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] pop_data_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count_reg != FULL_COUNT);
  assign pop_ok  = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        pop_data_reg <= mem[rd_ptr_reg];
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + (AW + 1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - (AW + 1)'(1);
      end
    end
  end

  assign pop_data = pop_data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in a sync_fifo and are sent
// 8 data bits LSB first, optional even parity, one or two stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);

  logic [1:0]  rst_sync_reg;
  logic        rst_int_n;
  tx_state_t   state_reg, state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic        uart_tx_reg, uart_tx_next;
  logic [2:0]  bit_idx_next;
  logic        fifo_pop;
  logic        fifo_has_data;
  logic        baud_tick;
  logic [7:0]  cur_byte;

  // Assertion reaches every flop at once; release waits two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= '0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_reg[1];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .push     (tx_valid && tx_ready),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .pop_data (cur_byte),
    .count    (fifo_count)
  );

  assign tx_ready      = rst_int_n && (fifo_count != FULL_COUNT);
  assign fifo_has_data = (fifo_count != '0);
  assign baud_tick     = (baud_cnt_reg == '0);

  // uart_tx is registered from the next-state value so the start bit appears on the pop edge.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    uart_tx_next  = uart_tx_reg;
    fifo_pop      = 1'b0;
    bit_idx_next  = bit_cnt_reg + 3'd1;
    if (state_reg != IDLE) begin
      baud_cnt_next = baud_tick ? BAUD_RELOAD : baud_cnt_reg - 16'd1;
    end
    case (state_reg)
      IDLE: begin
        uart_tx_next = 1'b1;
        if (fifo_has_data) begin
          fifo_pop      = 1'b1;
          state_next    = START;
          uart_tx_next  = 1'b0;
          baud_cnt_next = BAUD_RELOAD;
          bit_cnt_next  = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next   = DATA;
          uart_tx_next = cur_byte[0];
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = '0;
            if (PARITY_EN != 0) begin
              state_next   = PARITY;
              uart_tx_next = even_parity(cur_byte);
            end else begin
              state_next   = STOP;
              uart_tx_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_idx_next;
            uart_tx_next = cur_byte[bit_idx_next];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_next   = STOP;
          uart_tx_next = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_reg == LAST_STOP) begin
            bit_cnt_next = '0;
            if (fifo_has_data) begin
              fifo_pop     = 1'b1;
              state_next   = START;
              uart_tx_next = 1'b0;
            end else begin
              state_next   = IDLE;
              uart_tx_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_idx_next;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        uart_tx_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      uart_tx_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      uart_tx_reg  <= uart_tx_next;
    end
  end

  assign uart_tx = uart_tx_reg;
  assign tx_busy = (state_reg != IDLE);
  assign tx_done = (state_reg == STOP) && baud_tick && (bit_cnt_reg == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 depth 4, 8E2 depth 16) share one
// stimulus; each is checked every cycle against a queue-based line model.
module tb_uart_tx_fifo;

  localparam int BAUD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  bit         chk_en = 1'b0;
  bit         dec_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int DEPTH = (gi == 0) ? 4 : 16;
    localparam int PAR   = (gi == 0) ? 0 : 1;
    localparam int STOPB = (gi == 0) ? 1 : 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          tx_ready;
    logic          uart_tx;
    logic          tx_busy;
    logic          tx_done;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
      .BAUD_DIV  (BAUD),
      .FIFO_DEPTH(DEPTH),
      .PARITY_EN (PAR),
      .STOP_BITS (STOPB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .fifo_count(fifo_count)
    );

    // Model: a byte queue plus the remaining per-cycle line levels of the frame in flight.
    logic [7:0] fifo_q[$];
    bit         wave_q[$];
    int         rst_cnt = 0;
    bit         acc;
    logic [7:0] cur;

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fifo_q.delete();
        wave_q.delete();
        rst_cnt = 0;
      end else if (rst_cnt < 2) begin
        rst_cnt++;
      end else begin
        acc = tx_valid && (fifo_q.size() < DEPTH);
        if (wave_q.size() > 0) void'(wave_q.pop_front());
        if (wave_q.size() == 0 && fifo_q.size() > 0) begin
          cur = fifo_q.pop_front();
          $display("u%0d frame start 0x%02h at %0t", gi, cur, $time);
          for (int k = 0; k < BAUD; k++) wave_q.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int k = 0; k < BAUD; k++) wave_q.push_back(cur[b]);
          if (PAR != 0)
            for (int k = 0; k < BAUD; k++) wave_q.push_back(^cur);
          for (int k = 0; k < STOPB * BAUD; k++) wave_q.push_back(1'b1);
        end
        if (acc) fifo_q.push_back(tx_data);
      end
    end

    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        chk($sformatf("u%0d.uart_tx", gi), 32'(uart_tx),
            (wave_q.size() > 0) ? 32'(wave_q[0]) : 32'd1);
        chk($sformatf("u%0d.tx_busy", gi), 32'(tx_busy), 32'(wave_q.size() > 0));
        chk($sformatf("u%0d.tx_done", gi), 32'(tx_done), 32'(wave_q.size() == 1));
        chk($sformatf("u%0d.fifo_count", gi), 32'(fifo_count), 32'(fifo_q.size()));
        chk($sformatf("u%0d.tx_ready", gi), 32'(tx_ready),
            32'(rst_n && (rst_cnt >= 2) && (fifo_q.size() < DEPTH)));
      end
    end
  end

  // Mid-bit sampling receiver on the 8N1 instance.
  logic [7:0] dec_q[$];
  logic [7:0] dec_v;
  initial forever begin
    @(negedge clk);
    if (dec_en && g_dut[0].uart_tx == 1'b0) begin
      repeat (BAUD + BAUD / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        dec_v[b] = g_dut[0].uart_tx;
        if (b < 7) repeat (BAUD) @(negedge clk);
      end
      repeat (BAUD) @(negedge clk);
      chk("dec_stop", 32'(g_dut[0].uart_tx), 32'd1);
      dec_q.push_back(dec_v);
      $display("decoded 0x%02h at %0t", dec_v, $time);
    end
  end

  logic [9:0]  fr_a;
  logic [11:0] fr_b;
  logic [7:0]  exp_dec [3];
  int          low_cnt;

  initial begin
    exp_dec[0] = 8'h41;
    exp_dec[1] = 8'h42;
    exp_dec[2] = 8'h43;

    // Reset state
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_uart_tx", 32'(g_dut[0].uart_tx), 32'd1);
    chk("rst_tx_ready", 32'(g_dut[0].tx_ready), 32'd0);
    chk("rst_fifo_count", 32'(g_dut[0].fifo_count), 32'd0);
    chk("rst_tx_busy", 32'(g_dut[1].tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0x55 on 8N1: start + 1,0,1,0,1,0,1,0 + stop, 4 cycles each
    fr_a = {1'b1, 8'h55, 1'b0};
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("p55_line_at_accept", 32'(g_dut[0].uart_tx), 32'd1);
    chk("p55_count_at_accept", 32'(g_dut[0].fifo_count), 32'd1);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BAUD; k++) begin
        @(negedge clk);
        chk($sformatf("p55_bit%0d", i), 32'(g_dut[0].uart_tx), 32'(fr_a[i]));
        chk($sformatf("p55_done%0d", i), 32'(g_dut[0].tx_done), 32'(i == 9 && k == BAUD - 1));
      end
    end
    repeat (16) @(negedge clk);

    // 0x07 on 8E2: parity 1 after bit 7, then 8 high cycles with done on the last
    fr_b = {2'b11, 1'b1, 8'h07, 1'b0};
    tx_data = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < BAUD; k++) begin
        @(negedge clk);
        chk($sformatf("p07_bit%0d", i), 32'(g_dut[1].uart_tx), 32'(fr_b[i]));
        chk($sformatf("p07_done%0d", i), 32'(g_dut[1].tx_done), 32'(i == 11 && k == BAUD - 1));
      end
    end
    repeat (8) @(negedge clk);

    // Three back-to-back bytes
    dec_en = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h41;
    @(negedge clk);
    tx_data = 8'h42;
    @(negedge clk);
    tx_data = 8'h43;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_peak_count", 32'(g_dut[0].fifo_count), 32'd2);
    repeat (170) @(negedge clk);
    dec_en = 1'b0;
    chk("b2b_dec_count", 32'(dec_q.size()), 32'd3);
    for (int i = 0; i < dec_q.size(); i++) begin
      if (i < 3) chk($sformatf("b2b_dec%0d", i), 32'(dec_q[i]), 32'(exp_dec[i]));
    end

    // Hold tx_valid high: depth-4 instance fills and back-pressures
    tx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tx_data = 8'(8'h80 + i);
      @(negedge clk);
      if (i == 9) begin
        chk("full_count", 32'(g_dut[0].fifo_count), 32'd4);
        chk("full_ready", 32'(g_dut[0].tx_ready), 32'd0);
      end
    end
    tx_valid = 1'b0;
    repeat (620) @(negedge clk);

    // Reset during data bit 3 with two bytes queued
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    @(negedge clk);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_data = 8'h0F;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_pre_count", 32'(g_dut[0].fifo_count), 32'd2);
    chk("abort_pre_bit3", 32'(g_dut[0].uart_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_uart_tx", 32'(g_dut[0].uart_tx), 32'd1);
    chk("abort_fifo_count", 32'(g_dut[0].fifo_count), 32'd0);
    chk("abort_tx_busy", 32'(g_dut[0].tx_busy), 32'd0);
    chk("abort_tx_ready", 32'(g_dut[0].tx_ready), 32'd0);
    chk("abort_u1_uart_tx", 32'(g_dut[1].uart_tx), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready_sync1", 32'(g_dut[0].tx_ready), 32'd0);
    @(negedge clk);
    chk("release_ready_sync2", 32'(g_dut[0].tx_ready), 32'd1);
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (g_dut[0].uart_tx !== 1'b1 || g_dut[1].uart_tx !== 1'b1) low_cnt++;
    end
    chk("release_no_residual", 32'(low_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
